sipo_rx_16: RTL

Serial-to-parallel receiver that sits directly downstream of the 16-bit parallel-in/serial-out transmitter. It consumes the MSB-first serial bit stream and rebuilds WIDTH-bit words, using a sync strobe to locate the first bit of each word. Each complete word is presented on a registered valid/ready output port, so a downstream consumer can apply backpressure. Overrun and framing errors are flagged as sticky bits.

---
 rtl/sipo_rx_16_if.sv | 44 ++++
 rtl/sipo_rx_16.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sipo_rx_16_if.sv
// Bus bundle for the serial-to-parallel receiver: the serial input side
// (bit, sync, strobe), the registered valid/ready word output, and status.
interface sipo_rx_16_if #(
    parameter int WIDTH = 16
);
    logic             serial_in;
    logic             sync_in;
    logic             en;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    logic             clr_err;

    // Side that drives bits and consumes words (upstream transmitter + consumer)
    modport master (
        output serial_in,
        output sync_in,
        output en,
        output out_ready,
        output clr_err,
        input  out_data,
        input  out_valid,
        input  busy,
        input  overrun,
        input  frame_err
    );

    // Receiver side
    modport slave (
        input  serial_in,
        input  sync_in,
        input  en,
        input  out_ready,
        input  clr_err,
        output out_data,
        output out_valid,
        output busy,
        output overrun,
        output frame_err
    );
endinterface

// File: rtl/sipo_rx_16.sv
// Serial-to-parallel receiver. Rebuilds MSB-first words from a bit stream,
// using sync_in to mark each word's first bit, and hands complete words to
// a registered valid/ready output. Overrun and framing errors are sticky.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for an enabled bit with sync_in to start a word
//   S_SHIFT | word partially received; r_cnt bits already captured
module sipo_rx_16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    sipo_rx_16_if.slave   bus
);

    localparam logic [0:0]       S_IDLE   = 1'b0;
    localparam logic [0:0]       S_SHIFT  = 1'b1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Elaboration-time guard on the parameter ranges the datapath relies on.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("sipo_rx_16: WIDTH must be in 2..32");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt_w
        $error("sipo_rx_16: CNT_W too narrow to count WIDTH bits");
    end

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_frame_err;

    logic             w_in_idle;
    logic             w_start;
    logic             w_resync;
    logic             w_shift_bit;
    logic             w_complete;
    logic             w_accept;
    logic             w_load;
    logic             w_drop;
    logic             w_consume;
    logic [WIDTH-1:0] w_word;
    logic [WIDTH-1:0] w_first_bit;

    assign w_in_idle   = (r_state == S_IDLE);

    // A sync bit always begins a fresh word; in SHIFT it aborts the partial
    // word, and it takes priority even over the bit that would complete one.
    assign w_start     = bus.en &  bus.sync_in &  w_in_idle;
    assign w_resync    = bus.en &  bus.sync_in & ~w_in_idle;
    assign w_shift_bit = bus.en & ~bus.sync_in & ~w_in_idle;
    assign w_complete  = w_shift_bit & (r_cnt == LAST_CNT);

    assign w_word      = {r_shift[WIDTH-2:0], bus.serial_in};
    assign w_first_bit = {{(WIDTH-1){1'b0}}, bus.serial_in};

    // The output register can take a new word if empty or being drained now.
    assign w_accept    = ~r_out_valid | bus.out_ready;
    assign w_load      = w_complete &  w_accept;
    assign w_drop      = w_complete & ~w_accept;
    assign w_consume   = r_out_valid & bus.out_ready;

    // Framing FSM, bit counter and shift register; everything holds when en=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_start || w_resync) begin
            r_state <= S_SHIFT;
            r_cnt   <= ONE_CNT;
            r_shift <= w_first_bit;
        end else if (w_complete) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= w_word;
        end else if (w_shift_bit) begin
            r_cnt   <= r_cnt + ONE_CNT;
            r_shift <= w_word;
        end
    end

    // Output word register with valid/ready handshake; a completing word
    // replaces a word that is being consumed in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= w_word;
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a set event in the same cycle as clr_err wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_err) begin
                r_overrun <= 1'b0;
            end
            if (w_resync) begin
                r_frame_err <= 1'b1;
            end else if (bus.clr_err) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = (r_state == S_SHIFT);
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;

endmodule
